// File: rtl/change_dispenser.sv
// Change dispenser: queues change codes from the vending controller and pays them out coin by coin.
// Optional per-tube coin tallies are compiled in with `define CHANGE_DISP_TALLY_EN.
module change_dispenser #(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] change,
  input  logic       coin_drop,
  input  logic       fault_clr,
  output logic       eject5,
  output logic       eject10,
  output logic       busy,
  output logic       fifo_full,
  output logic       fault,
  output logic       overflow
`ifdef CHANGE_DISP_TALLY_EN
  ,
  output logic [7:0] coins5_out,
  output logic [7:0] coins10_out
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, P10, W10, P5, W5, FAULT} state_t;

  state_t        state;
  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] cnt;
  logic          pending5;
  logic          drop_seen;
  logic          fifo_empty;
  logic          pop;
  logic          push;
  logic          drop_ok;
  logic [1:0]    head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign pop        = (state == IDLE) && !fifo_empty;
  // A pop on the same edge frees a slot, so a push into a full queue still lands.
  assign push       = (change != 2'b00) && (!fifo_full || pop);
  assign drop_ok    = coin_drop || drop_seen;

  assign eject10 = (state == P10);
  assign eject5  = (state == P5);
  assign busy    = (state != IDLE) || !fifo_empty;

  // NOTE: queue storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= change;
  end

  // NOTE: every clocked block uses non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if ((change != 2'b00) && !push) overflow <= 1'b1;
      else if (fault_clr)             overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pending5  <= 1'b0;
      drop_seen <= 1'b0;
      fault     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            cnt       <= '0;
            drop_seen <= 1'b0;
            pending5  <= (head == 2'b11);
            if (head == 2'b01) state <= P5;
            else               state <= P10;
          end
        end
        P10, P5: begin
          cnt <= cnt + 1'b1;
          if (coin_drop) drop_seen <= 1'b1;
          if (cnt == PULSE_LAST) begin
            if (state == P10) state <= W10;
            else              state <= W5;
          end
        end
        W10, W5: begin
          cnt <= cnt + 1'b1;
          // A drop on the timeout edge still counts as a successful payout.
          if (drop_ok) begin
            drop_seen <= 1'b0;
            if ((state == W10) && pending5) begin
              state    <= P5;
              pending5 <= 1'b0;
              cnt      <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            state    <= FAULT;
            fault    <= 1'b1;
            pending5 <= 1'b0;
          end
        end
        FAULT: begin
          if (fault_clr) begin
            state <= IDLE;
            fault <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CHANGE_DISP_TALLY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      coins5_out  <= '0;
      coins10_out <= '0;
    end else begin
      if ((state == W5) && drop_ok && (coins5_out != 8'hff))
        coins5_out <= coins5_out + 1'b1;
      if ((state == W10) && drop_ok && (coins10_out != 8'hff))
        coins10_out <= coins10_out + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser; tally checks compile in with CHANGE_DISP_TALLY_EN.
module tb_change_dispenser;

  localparam int PULSE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] change;
  logic       coin_drop;
  logic       fault_clr;
  logic       eject5;
  logic       eject10;
  logic       busy;
  logic       fifo_full;
  logic       fault;
  logic       overflow;
`ifdef CHANGE_DISP_TALLY_EN
  logic [7:0] coins5_out;
  logic [7:0] coins10_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  change_dispenser #(.PULSE_CYCLES(4), .TIMEOUT_CYCLES(64), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .change     (change),
    .coin_drop  (coin_drop),
    .fault_clr  (fault_clr),
    .eject5     (eject5),
    .eject10    (eject10),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fault      (fault),
    .overflow   (overflow)
`ifdef CHANGE_DISP_TALLY_EN
    ,
    .coins5_out (coins5_out),
    .coins10_out(coins10_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // Single IDLE cycle between queued requests.
  task automatic turnaround(input string tag);
    check({tag, "_turn_busy"}, busy, 1);
    check({tag, "_turn_ej"}, {eject10, eject5}, 0);
    step(1);
  endtask

  task automatic pulse_and_drop(input logic is10, input string tag);
    for (int i = 0; i < PULSE; i++) begin
      check({tag, "_ej10"}, eject10, is10);
      check({tag, "_ej5"}, eject5, !is10);
      step(1);
    end
    check({tag, "_wait_ej"}, {eject10, eject5}, 0);
    coin_drop = 1'b1;
    step(1);
    coin_drop = 1'b0;
  endtask

  // Starts on the first pulse cycle of a request, ends the cycle after its last drop is accepted.
  task automatic serve(input logic [1:0] code, input string tag);
    if (code != 2'b01) pulse_and_drop(1'b1, {tag, "_c10"});
    if (code != 2'b10) pulse_and_drop(1'b0, {tag, "_c5"});
  endtask

  initial begin
    rst = 1'b1; change = 2'b00; coin_drop = 1'b0; fault_clr = 1'b0;
    step(2);
    check("rst_outs", {eject5, eject10, busy, fifo_full, fault, overflow}, 0);
`ifdef CHANGE_DISP_TALLY_EN
    check("rst_tally", {coins5_out, coins10_out}, 0);
`endif
    rst = 1'b0;

    // Single 5: request in cycle N, pulse N+2..N+5, drop at N+9.
    change = 2'b01;
    check("s5_busy_n", busy, 0);
    step(1);
    change = 2'b00;
    check("s5_busy_n1", busy, 1);
    check("s5_ej_n1", eject5, 0);
    step(1);
    for (int i = 0; i < PULSE; i++) begin
      check("s5_ej5_hi", eject5, 1);
      check("s5_ej10_lo", eject10, 0);
      step(1);
    end
    check("s5_ej5_fall", eject5, 0);
    step(3);
    check("s5_busy_wait", busy, 1);
    coin_drop = 1'b1;
    step(1);
    coin_drop = 1'b0;
    check("s5_busy_done", busy, 0);

    // Code 15: 10-pulse, drop, 5-pulse immediately, drop.
    do_reset();
    change = 2'b11;
    step(1);
    change = 2'b00;
    turnaround("c15");
    serve(2'b11, "c15");
    check("c15_busy_done", busy, 0);
`ifdef CHANGE_DISP_TALLY_EN
    check("c15_coins10", coins10_out, 1);
    check("c15_coins5", coins5_out, 1);
`endif

    // Queue fill: first request in service, six pushes, four fit.
    do_reset();
    change = 2'b10;
    step(1);
    change = 2'b00;
    step(1);
    check("qf_p10", eject10, 1);
    change = 2'b01; step(1);
    change = 2'b10; step(1);
    change = 2'b01; step(1);
    change = 2'b11;
    check("qf_not_full3", fifo_full, 0);
    step(1);
    change = 2'b01;
    check("qf_full4", fifo_full, 1);
    check("qf_no_ovf_yet", overflow, 0);
    step(1);
    change = 2'b10; step(1);
    change = 2'b00;
    check("qf_full_after6", fifo_full, 1);
    check("qf_ovf_after6", overflow, 1);
    coin_drop = 1'b1;
    fault_clr = 1'b1;
    step(1);
    coin_drop = 1'b0;
    fault_clr = 1'b0;
    check("qf_ovf_cleared", overflow, 0);
    change = 2'b01;
    turnaround("qf0");
    change = 2'b00;
    check("qf_push_pop_full", fifo_full, 1);
    check("qf_push_pop_noovf", overflow, 0);
    serve(2'b01, "qf1");
    turnaround("qf1");
    serve(2'b10, "qf2");
    turnaround("qf2");
    serve(2'b01, "qf3");
    turnaround("qf3");
    serve(2'b11, "qf4");
    turnaround("qf4");
    serve(2'b01, "qf5");
    check("qf_busy_done", busy, 0);
    check("qf_empty_not_full", fifo_full, 0);

    // Timeout: 10 request, no drop; fault_clr on the timeout edge is ignored.
    do_reset();
    change = 2'b10;
    step(1);
    change = 2'b00;
    step(1);
    check("to_ej10_rise", eject10, 1);
    step(3);
    check("to_ej10_last", eject10, 1);
    step(1);
    check("to_ej10_fall", eject10, 0);
    step(4);
    change = 2'b01;
    step(1);
    change = 2'b00;
    step(54);
    check("to_no_fault_63", fault, 0);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("to_fault_64", fault, 1);
    check("to_fault_ej", {eject10, eject5}, 0);
    check("to_fault_busy", busy, 1);
    change = 2'b10;
    step(1);
    change = 2'b00;
    coin_drop = 1'b1;
    step(1);
    coin_drop = 1'b0;
    check("to_drop_ignored", fault, 1);
    check("to_fault_ej2", {eject10, eject5}, 0);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("to_fault_cleared", fault, 0);
    turnaround("to0");
    serve(2'b01, "to1");
    turnaround("to1");
    serve(2'b10, "to2");
    check("to_busy_done", busy, 0);

    // Race: drop on the edge the counter reaches 64.
    do_reset();
    change = 2'b10;
    step(1);
    change = 2'b00;
    step(1);
    check("race_ej10", eject10, 1);
    step(63);
    check("race_pre_fault", fault, 0);
    coin_drop = 1'b1;
    step(1);
    coin_drop = 1'b0;
    check("race_no_fault", fault, 0);
    check("race_idle", busy, 0);
`ifdef CHANGE_DISP_TALLY_EN
    check("race_coins10", coins10_out, 1);
`endif

    // Reset mid-pulse with a request queued behind.
    do_reset();
    change = 2'b10;
    step(1);
    change = 2'b01;
    step(1);
    change = 2'b00;
    check("rmp_ej10", eject10, 1);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rmp_ej10_low", eject10, 0);
    check("rmp_busy", busy, 0);
    check("rmp_full", fifo_full, 0);
    step(2);
    check("rmp_queue_lost", {busy, eject5, eject10}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Back-end companion to the vending machine controller: consumes the controller's `change` code and physically pays it out. Requests are queued in a small FIFO and serviced one coin at a time, each by a timed ejector-solenoid pulse followed by a wait for the coin-drop sensor acknowledgment. A missing acknowledgment latches a fault until it is cleared.

## Interface
- `PULSE_CYCLES`, 4: ejector pulse width in clock cycles, ≥1.
- `TIMEOUT_CYCLES`, 64: maximum cycles allowed from the first pulse cycle to `coin_drop`, and must exceed `PULSE_CYCLES`.
- `FIFO_DEPTH`, 4: request queue entries, power of two, ≥2.
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `change` input 2: change request from the vending controller, in units of 5. 00 = none, 01 = 5, 10 = 10, 11 = 15.
- `coin_drop` input 1: drop sensor, synchronous to `clk`, high for ≥1 cycle per coin.
- `fault_clr` input 1: single-cycle clear of `fault` and `overflow`.
- `eject5` output 1: 5-unit tube solenoid.
- `eject10` output 1: 10-unit tube solenoid.
- `busy` output 1: the FSM is not in IDLE, or the FIFO is non-empty.
- `fifo_full` output 1: the FIFO holds `FIFO_DEPTH` entries.
- `fault` output 1: sticky flag, set on a drop timeout.
- `overflow` output 1: sticky flag, set when a request is dropped.
- `coins5_out`, `coins10_out` output 8 each: present only with the tally feature (see Configuration).

## Operation
- **Push rule**
  - Any cycle with `change != 00` is one request. The controller presents a code for exactly one cycle.
  - The request is written at that edge if the FIFO is not full, or if a pop happens on the same edge.
  - Otherwise the request is discarded and `overflow` is set.
- **FSM states:** IDLE, P10, W10, P5, W5, FAULT. Outputs are Moore, decoded from registered state.
  - `eject10` is high only in P10. `eject5` is high only in P5.
- **IDLE**
  - If the FIFO is non-empty, pop the head.
  - Code 01 → P5. Code 10 or 11 → P10.
  - The popped code is held in a `pending5` register, which is 1 for code 11.
- **P10 / P5**
  - Stay for exactly `PULSE_CYCLES` cycles, then go to W10 / W5.
- **W10 / W5:** wait for `coin_drop`.
  - A single timeout counter starts at 0 on entry to Pn and increments every cycle through Pn and Wn.
  - `coin_drop` is sampled in Pn and Wn. A drop seen during Pn is remembered, and the exit is taken on entry to Wn.
- **On a drop**
  - From W10: if `pending5` is set → P5 and clear `pending5`; otherwise → IDLE.
  - From W5 → IDLE.
- **On timeout:** when the counter reaches `TIMEOUT_CYCLES` with no drop → FAULT, and set `fault`.
- **FAULT**
  - Both ejectors stay low.
  - The current request, including any `pending5`, is abandoned.
  - The FIFO keeps accepting pushes.
  - `fault_clr` → IDLE and clears `fault` and `overflow`.
- `fault_clr` in any other state clears only `overflow`.
- `coin_drop` in IDLE or FAULT is ignored.

## Timing
- **Reset values:** state IDLE, FIFO empty, counters 0, `pending5` 0. All outputs are 0, including the tallies.
- **Reset mid-operation**
  - The ejector drops on the first cycle after the reset edge.
  - Queued requests are lost.
- **Latency:** with `change` valid in cycle N and the FSM idle:
  - the FIFO is non-empty after edge N+1;
  - `eject*` is high in cycles N+2 … N+1+`PULSE_CYCLES`.
- **Back-to-back coins:** for code 11, `eject5` rises the cycle after the edge on which W10 sees the drop. There is no gap state.
- **Queue turnaround:** with the FIFO non-empty, IDLE lasts exactly one cycle between requests.
- **Simultaneous events**
  - Push while full, with a pop on the same edge: the request is accepted.
  - `coin_drop` on the same edge the counter reaches timeout: the drop wins.
  - `fault_clr` on the same edge as a timeout: the fault is set, and the clear is ignored.
- **Pointer width:** FIFO pointers are log2(`FIFO_DEPTH`)+1 bits and wrap naturally.

## Configuration
- **Macro `CHANGE_DISP_TALLY_EN`**
  - **Defined:** adds the `coins5_out` and `coins10_out` ports.
    - Each increments on the edge that accepts a drop in W5 or W10.
    - Each saturates at 255.
    - Each resets to 0 only on `rst`; `fault_clr` does not affect them.
  - **Undefined:** the ports and counters do not exist, and all other behaviour is identical.

## Test plan
- **Single 5:** after reset, drive `change=01` for 1 cycle and drop 3 cycles after `eject5` falls.
  - Required: `eject5` high for 4 cycles starting 2 cycles after the request.
  - Required: `busy` falls the cycle after the drop is accepted.
- **Code 15:** drive `change=11` with prompt drops.
  - Required: a 4-cycle `eject10` pulse, then a 4-cycle `eject5` pulse.
  - With the tally feature: `coins10_out=1` and `coins5_out=1`.
- **Queue fill:** push 6 requests on consecutive cycles while the first is in service with no drops.
  - Required: 4 accepted in total, `fifo_full=1`, and `overflow=1` after the 6th.
  - Required: the remaining queued requests are then serviced in order.
- **Timeout:** a single 10 request with no drop.
  - Required: `fault=1` exactly 64 cycles after `eject10` rises, with both ejectors low.
  - Required: `fault_clr` returns the FSM to IDLE, and the next queued request is then serviced.
- **Race:** raise `coin_drop` on the cycle the counter reaches 64.
  - Required: no fault, and the FSM returns to IDLE.
- **Reset mid-pulse:** assert `rst` during P10.
  - Required: `eject10` is 0 the next cycle, with `busy=0` and `fifo_full=0`.
